// File: rtl/final_exam.sv
// Five-LED pattern generator: divides the board clock to a step tick and animates
// Q with one of four switch-selected patterns (S2,S1 pattern; S0 direction/mirror).
module final_exam #(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic       CLK50MHz,
    input  logic       RST,
    input  logic       S0,
    input  logic       S1,
    input  logic       S2,
    output logic [4:0] Q
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    mode;
    logic [CW-1:0] cnt;
    logic [2:0]    phase;
    logic [2:0]    phase_nxt;
    logic [4:0]    q_init;
    logic [4:0]    q_nxt;
    logic          mode_change;
    logic          tick;

    function automatic logic [4:0] bit_rev(input logic [4:0] v);
        return {v[0], v[1], v[2], v[3], v[4]};
    endfunction

    function automatic logic [4:0] bar_fill(input logic [2:0] n);
        case (n)
            3'd0:    return 5'b00000;
            3'd1:    return 5'b00001;
            3'd2:    return 5'b00011;
            3'd3:    return 5'b00111;
            3'd4:    return 5'b01111;
            default: return 5'b11111;
        endcase
    endfunction

    function automatic logic [4:0] ping_pong(input logic [2:0] p);
        case (p)
            3'd0:    return 5'b00001;
            3'd1:    return 5'b00010;
            3'd2:    return 5'b00100;
            3'd3:    return 5'b01000;
            3'd4:    return 5'b10000;
            3'd5:    return 5'b01000;
            3'd6:    return 5'b00100;
            default: return 5'b00010;
        endcase
    endfunction

    always_comb begin
        mode_change = (sync2 != mode);
        tick        = (cnt == CNT_LAST);

        // Initial value depends on the incoming mode, not the stored one.
        case (sync2[2:1])
            2'b00:   q_init = sync2[0] ? 5'b11111 : 5'b00000;
            2'b01:   q_init = sync2[0] ? 5'b10000 : 5'b00001;
            2'b10:   q_init = 5'b00000;
            default: q_init = sync2[0] ? 5'b10000 : 5'b00001;
        endcase

        phase_nxt = phase;
        q_nxt     = Q;
        case (mode[2:1])
            2'b00: q_nxt = mode[0] ? (Q - 5'd1) : (Q + 5'd1);
            2'b01: q_nxt = mode[0] ? {Q[0], Q[4:1]} : {Q[3:0], Q[4]};
            2'b10: begin
                phase_nxt = (phase == 3'd5) ? 3'd0 : (phase + 3'd1);
                q_nxt     = mode[0] ? bit_rev(bar_fill(phase_nxt)) : bar_fill(phase_nxt);
            end
            default: begin
                phase_nxt = phase + 3'd1;
                q_nxt     = mode[0] ? bit_rev(ping_pong(phase_nxt)) : ping_pong(phase_nxt);
            end
        endcase
    end

    always_ff @(posedge CLK50MHz or negedge RST) begin
        if (!RST) begin
            sync1 <= 3'b000;
            sync2 <= 3'b000;
            mode  <= 3'b000;
            cnt   <= '0;
            phase <= 3'd0;
            Q     <= 5'b00000;
        end else begin
            sync1 <= {S2, S1, S0};
            sync2 <= sync1;
            // A reload restarts the step period and beats a coincident tick.
            if (mode_change) begin
                mode  <= sync2;
                cnt   <= '0;
                phase <= 3'd0;
                Q     <= q_init;
            end else begin
                cnt <= tick ? '0 : (cnt + CW'(1));
                if (tick) begin
                    phase <= phase_nxt;
                    Q     <= q_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_final_exam.sv
// Bench for final_exam: randomized switch stimulus checked every clock against
// a sequence-index model of the four LED patterns.
module tb_final_exam;

    localparam int TICK_DIV = 4;

    logic       CLK50MHz = 1'b0;
    logic       RST      = 1'b0;
    logic       S0       = 1'b0;
    logic       S1       = 1'b0;
    logic       S2       = 1'b0;
    logic [4:0] Q;

    int checks = 0;
    int errors = 0;

    // Model: switch pipeline, active mode, clocks since reload, steps since reload.
    logic [2:0] m_s1;
    logic [2:0] m_s2;
    logic [2:0] m_mode;
    int         m_cyc;
    int         m_k;

    final_exam #(.TICK_DIV(TICK_DIV)) dut (
        .CLK50MHz(CLK50MHz),
        .RST     (RST),
        .S0      (S0),
        .S1      (S1),
        .S2      (S2),
        .Q       (Q)
    );

    always #10 CLK50MHz = ~CLK50MHz;

    function automatic logic [4:0] exp_pattern(input logic [2:0] md, input int k);
        int n;
        int pos;
        case (md[2:1])
            2'b00: begin
                n = k % 32;
                return md[0] ? 5'(31 - n) : 5'(n);
            end
            2'b01: begin
                n = k % 5;
                return md[0] ? 5'(16 >> n) : 5'(1 << n);
            end
            2'b10: begin
                n = k % 6;
                return md[0] ? 5'((31 << (5 - n)) & 31) : 5'((1 << n) - 1);
            end
            default: begin
                n   = k % 8;
                pos = (n <= 4) ? n : 8 - n;
                return md[0] ? 5'(16 >> pos) : 5'(1 << pos);
            end
        endcase
    endfunction

    task automatic model_reset();
        m_s1   = 3'b000;
        m_s2   = 3'b000;
        m_mode = 3'b000;
        m_cyc  = 0;
        m_k    = 0;
    endtask

    task automatic set_s(input logic [2:0] v);
        {S2, S1, S0} = v;
    endtask

    task automatic assert_reset();
        RST = 1'b0;
        model_reset();
    endtask

    // Advances one clock, updates the model, and leaves time 1 unit past the edge.
    task automatic clk_step();
        @(posedge CLK50MHz);
        if (RST) begin
            if (m_s2 != m_mode) begin
                m_mode = m_s2;
                m_k    = 0;
                m_cyc  = 0;
            end else begin
                if (m_cyc % TICK_DIV == TICK_DIV - 1) m_k++;
                m_cyc++;
            end
            m_s2 = m_s1;
            m_s1 = {S2, S1, S0};
        end
        #1;
    endtask

    task automatic test_reset();
        assert_reset();
        for (int i = 0; i < 1000; i++) begin
            set_s(3'($urandom_range(0, 7)));
            clk_step();
            checks++;
            if (Q !== 5'b00000) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got=%b exp=00000", i, Q);
            end
        end
    endtask

    task automatic test_mode0_count();
        assert_reset();
        set_s(3'b000);
        clk_step();
        RST = 1'b1;
        for (int i = 0; i < 4 * 32 + 8; i++) begin
            clk_step();
            checks++;
            if (Q !== exp_pattern(m_mode, m_k)) begin
                errors++;
                $display("FAIL count_up cyc=%0d got=%b exp=%b", i, Q, exp_pattern(m_mode, m_k));
            end
            if (i == 126) begin
                checks++;
                if (Q !== 5'b11111) begin
                    errors++;
                    $display("FAIL count_up_top got=%b exp=11111", Q);
                end
            end
            if (i == 127) begin
                checks++;
                if (Q !== 5'b00000) begin
                    errors++;
                    $display("FAIL count_up_wrap got=%b exp=00000", Q);
                end
            end
        end
    endtask

    task automatic test_pingpong();
        assert_reset();
        set_s(3'b110);
        clk_step();
        RST = 1'b1;
        for (int i = 0; i < 3; i++) clk_step();
        checks++;
        if (Q !== 5'b00001) begin
            errors++;
            $display("FAIL pingpong_reload got=%b exp=00001", Q);
        end
        for (int i = 0; i < 40; i++) begin
            clk_step();
            checks++;
            if (Q !== exp_pattern(m_mode, m_k)) begin
                errors++;
                $display("FAIL pingpong cyc=%0d got=%b exp=%b", i, Q, exp_pattern(m_mode, m_k));
            end
        end
    endtask

    task automatic test_single_rev();
        set_s(3'b011);
        for (int i = 0; i < 3; i++) begin
            clk_step();
            checks++;
            if (Q !== exp_pattern(m_mode, m_k)) begin
                errors++;
                $display("FAIL single_rev_load cyc=%0d got=%b exp=%b", i, Q, exp_pattern(m_mode, m_k));
            end
        end
        checks++;
        if (Q !== 5'b10000) begin
            errors++;
            $display("FAIL single_rev_init got=%b exp=10000", Q);
        end
        for (int i = 0; i < 24; i++) begin
            clk_step();
            checks++;
            if (Q !== exp_pattern(m_mode, m_k)) begin
                errors++;
                $display("FAIL single_rev cyc=%0d got=%b exp=%b", i, Q, exp_pattern(m_mode, m_k));
            end
        end
    endtask

    task automatic test_bar_reset();
        set_s(3'b100);
        for (int i = 0; i < 30; i++) begin
            clk_step();
            checks++;
            if (Q !== exp_pattern(m_mode, m_k)) begin
                errors++;
                $display("FAIL bar_fill cyc=%0d got=%b exp=%b", i, Q, exp_pattern(m_mode, m_k));
            end
        end
        #4;
        assert_reset();
        #1;
        checks++;
        if (Q !== 5'b00000) begin
            errors++;
            $display("FAIL async_reset got=%b exp=00000", Q);
        end
        clk_step();
        checks++;
        if (Q !== 5'b00000) begin
            errors++;
            $display("FAIL reset_after_edge got=%b exp=00000", Q);
        end
    endtask

    task automatic test_tick_priority();
        int waited;
        assert_reset();
        set_s(3'b001);
        clk_step();
        RST = 1'b1;
        for (int i = 0; i < 3; i++) clk_step();
        checks++;
        if (Q !== 5'b11111) begin
            errors++;
            $display("FAIL down_init got=%b exp=11111", Q);
        end
        for (int i = 0; i < 4; i++) clk_step();
        checks++;
        if (Q !== 5'b11110) begin
            errors++;
            $display("FAIL down_step got=%b exp=11110", Q);
        end
        // Time the switch change so the reload edge coincides with a tick edge.
        waited = 0;
        while (m_cyc % TICK_DIV != 1 && waited < 8) begin
            clk_step();
            waited++;
        end
        checks++;
        if (m_cyc % TICK_DIV != 1) begin
            errors++;
            $display("FAIL tick_align_timeout waited=%0d", waited);
        end
        set_s(3'b010);
        for (int i = 0; i < 3; i++) clk_step();
        checks++;
        if (Q !== 5'b00001) begin
            errors++;
            $display("FAIL reload_priority got=%b exp=00001", Q);
        end
        for (int i = 0; i < 8; i++) begin
            clk_step();
            checks++;
            if (Q !== exp_pattern(m_mode, m_k)) begin
                errors++;
                $display("FAIL after_priority cyc=%0d got=%b exp=%b", i, Q, exp_pattern(m_mode, m_k));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) set_s(3'($urandom_range(0, 7)));
            clk_step();
            checks++;
            if (Q !== exp_pattern(m_mode, m_k)) begin
                errors++;
                $display("FAIL random cyc=%0d mode=%b got=%b exp=%b", i, m_mode, Q, exp_pattern(m_mode, m_k));
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_mode0_count();
        test_pingpong();
        test_single_rev();
        test_bar_reset();
        test_tick_priority();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
